// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer for the RV32IM core: owns the PC, keeps one instruction-memory
// request in flight, hands fetched words to decode, and handles redirects and misaligned-target faults.
`timescale 1ns/1ps

module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault,
    output logic [31:0] fault_pc
);

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        OUT,
        DROP,
        FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        target_aligned;

    assign target_aligned = (redirect_pc[1:0] == 2'b00);

    // NOTE: every signal written here gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        if (redirect_valid) begin
            // While a request is in flight its response must be swallowed before
            // moving on, unless it is arriving in this very cycle.
            if (target_aligned) begin
                pc_d    = redirect_pc;
                fault_d = 1'b0;
                if (state_q == WAIT || state_q == DROP) begin
                    state_d = imem_rsp_valid ? FETCH : DROP;
                end else begin
                    state_d = FETCH;
                end
            end else begin
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
                if (state_q == WAIT || state_q == DROP) begin
                    state_d = imem_rsp_valid ? FAULT : DROP;
                end else begin
                    state_d = FAULT;
                end
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_req_ready) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = req_pc_q;
                        state_d   = OUT;
                    end
                end
                OUT: begin
                    if (inst_ready) begin
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    // A misaligned redirect taken while busy parks here with the fault already raised.
                    if (imem_rsp_valid) begin
                        state_d = fault_q ? FAULT : FETCH;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign imem_req_valid = (state_q == FETCH) && !redirect_valid && !rst;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == OUT);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fault          = fault_q;
    assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level model of the fetch unit and its memory.
`timescale 1ns/1ps

module tb_fetch_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fault;
    logic [31:0] fault_pc;

    fetch_pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Drive controls for the next cycle.
    logic        d_rv, d_rdy, d_irdy;
    logic [31:0] d_rpc;
    bit          rand_mode;
    int          mem_lat;

    // Reference model: what the fetch unit is doing, not how it encodes it.
    logic [31:0] m_pc, m_req_addr, m_inst, m_ipc, m_fpc;
    bit          m_busy, m_stale, m_have, m_fault;

    // Memory model: a single pending request with a countdown.
    bit          mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;

    logic [31:0] acc_q [$];
    logic [31:0] pres_q [$];
    int          pres_t [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h0BAD_0000;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q [$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_req_addr = '0; m_inst = '0; m_ipc = '0; m_fpc = '0;
        m_busy = 0; m_stale = 0; m_have = 0; m_fault = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_fault"}, {31'b0, fault}, 32'd0);
        check({tag, "_fault_pc"}, fault_pc, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the models.
    task automatic step();
        logic        rsp, e_req, acc;
        logic [31:0] rdata;
        rsp   = mem_pending && (mem_cnt == 0);
        rdata = mem_data(mem_addr);
        if (!mem_pending && rand_mode && $urandom_range(0, 7) == 0) begin
            rsp   = 1'b1;
            rdata = $urandom;
        end
        redirect_valid = d_rv;
        redirect_pc    = d_rpc;
        imem_req_ready = d_rdy;
        inst_ready     = d_irdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;

        @(negedge clk);
        e_req = !m_busy && !m_have && !m_fault && !d_rv;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
        check("req_addr", imem_req_addr, m_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
        check("inst", inst, m_inst);
        check("inst_pc", inst_pc, m_ipc);
        check("fault", {31'b0, fault}, {31'b0, m_fault});
        check("fault_pc", fault_pc, m_fpc);
        if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
        if (inst_valid && inst_ready && !redirect_valid) begin
            pres_q.push_back(inst_pc);
            pres_t.push_back(cyc);
        end

        acc = e_req && d_rdy;
        if (d_rv) begin
            if (d_rpc[1:0] == 2'b00) begin
                m_pc    = d_rpc;
                m_fault = 0;
            end else begin
                m_fault = 1;
                m_fpc   = d_rpc;
            end
            m_have = 0;
            if (m_busy) begin
                if (rsp) m_busy = 0;
                else     m_stale = 1;
            end
        end else if (acc) begin
            m_busy     = 1;
            m_stale    = 0;
            m_req_addr = m_pc;
            m_pc       = m_pc + 32'd4;
        end else if (m_busy && rsp) begin
            m_busy = 0;
            if (!m_stale) begin
                m_have = 1;
                m_inst = rdata;
                m_ipc  = m_req_addr;
            end
        end else if (m_have && d_irdy) begin
            m_have = 0;
        end

        if (mem_pending && mem_cnt == 0) mem_pending = 0;
        else if (mem_pending)            mem_cnt--;
        if (acc) begin
            mem_pending = 1;
            mem_cnt     = rand_mode ? int'($urandom_range(0, 2)) : mem_lat;
            mem_addr    = m_req_addr;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
        d_rv = 0; d_rpc = 0; d_rdy = 0; d_irdy = 0;
        rand_mode = 0; mem_lat = 0; mem_pending = 0; mem_cnt = 0; mem_addr = 0;
        model_reset();
        do_reset("rst");

        // Sequential fetch, 1-cycle memory, decode always ready.
        d_rdy = 1; d_irdy = 1; mem_lat = 0;
        repeat (9) step();
        check("seq_req0", q_at(acc_q, 0), 32'h100);
        check("seq_req1", q_at(acc_q, 1), 32'h104);
        check("seq_req2", q_at(acc_q, 2), 32'h108);
        check("seq_pres0", q_at(pres_q, 0), 32'h100);
        check("seq_pres2", q_at(pres_q, 2), 32'h108);
        check("seq_gap", (pres_t.size() > 1) ? 32'(pres_t[1] - pres_t[0]) : 32'd0, 32'd3);

        // Backpressure in OUT.
        do_reset("bp");
        d_irdy = 0;
        repeat (2) step();
        repeat (5) step();
        check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("bp_inst_pc", inst_pc, 32'h100);
        check("bp_inst", inst, mem_data(32'h100));
        check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        d_irdy = 1;
        acc_q.delete();
        step();
        mem_lat = 2;
        step();
        check("bp_next_req", q_at(acc_q, 0), 32'h104);

        // Redirect while waiting; response two cycles later.
        pres_q.delete();
        d_rv = 1; d_rpc = 32'h200;
        step();
        d_rv = 0;
        repeat (2) step();
        mem_lat = 0;
        acc_q.delete();
        step();
        check("rw_next_req", q_at(acc_q, 0), 32'h200);
        // Response in the same cycle as the redirect.
        d_rv = 1;
        step();
        d_rv = 0;
        step();
        check("rw_same_cnt", 32'(acc_q.size()), 32'd2);
        check("rw_same_req", q_at(acc_q, 1), 32'h200);
        check("rw_no_present", 32'(pres_q.size()), 32'd0);

        // Redirect against presentation, then against a fetch.
        step();
        d_rv = 1; d_rpc = 32'h300; d_irdy = 1;
        step();
        check("ro_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("ro_no_present", 32'(pres_q.size()), 32'd0);
        acc_q.delete();
        step();
        d_rv = 0;
        step();
        check("rf_req_cnt", 32'(acc_q.size()), 32'd1);
        check("rf_req", q_at(acc_q, 0), 32'h300);

        // Misaligned redirect and recovery.
        repeat (2) step();
        d_rv = 1; d_rpc = 32'h302;
        step();
        d_rv = 0;
        acc_q.delete();
        repeat (3) step();
        check("mis_fault", {31'b0, fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h302);
        check("mis_no_req", 32'(acc_q.size()), 32'd0);
        d_rv = 1; d_rpc = 32'h400;
        step();
        check("mis_clear", {31'b0, fault}, 32'd0);
        d_rv = 0;
        step();
        check("mis_req", q_at(acc_q, 0), 32'h400);

        // PC wrap.
        repeat (2) step();
        d_rv = 1; d_rpc = 32'hFFFF_FFFC;
        step();
        d_rv = 0;
        acc_q.delete();
        repeat (3) step();
        mem_lat = 2;
        step();
        check("wrap_req0", q_at(acc_q, 0), 32'hFFFF_FFFC);
        check("wrap_req1", q_at(acc_q, 1), 32'h0000_0000);

        // Reset during WAIT; the late response must be ignored.
        do_reset("wrst");
        d_rdy = 0;
        repeat (3) step();
        mem_lat = 0; d_rdy = 1;
        acc_q.delete();
        repeat (2) step();
        check("wrst_req", q_at(acc_q, 0), RST_PC);
        check("wrst_inst_pc", inst_pc, RST_PC);
        check("wrst_inst", inst, mem_data(RST_PC));

        // Random traffic.
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            d_rv  = ($urandom_range(0, 9) == 0);
            d_rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) d_rpc[1:0] = 2'($urandom_range(1, 3));
            d_rdy  = ($urandom_range(0, 3) != 0);
            d_irdy = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the RV32IM core.
- Issues one instruction-memory request at a time and presents each fetched instruction with its PC to decode over a valid/ready handshake.
- Accepts redirects (the pc_next value from pc_control on a taken branch, JAL or JALR), discards stale responses, and raises a fault on misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  a taken branch or jump is resolved this cycle.
- redirect_pc  in  32  target PC, valid when redirect_valid is high.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  fetch address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response for the single outstanding request.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  inst/inst_pc hold a live instruction.
- inst  out  32  instruction to decode.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode accepts the instruction.
- fault  out  1  misaligned-fetch fault pending.
- fault_pc  out  32  offending target.

Behaviour:
- States: FETCH, WAIT, OUT, DROP, FAULT. Registers: pc_q, req_pc_q, inst_q, inst_pc_q.
- Reset (async, any state, mid-transaction): state=FETCH, pc_q=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fault=0, fault_pc=0.
- imem_req_valid is 0 while rst is high.
- imem_req_valid = (state==FETCH) && !redirect_valid. imem_req_addr = pc_q. The address may change while ready is low.
- FETCH:
  - On valid && ready: req_pc_q<=pc_q, pc_q<=pc_q+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0), go to WAIT.
- WAIT:
  - On imem_rsp_valid: inst_q<=imem_rsp_data, inst_pc_q<=req_pc_q, go to OUT.
- OUT:
  - inst_valid=1. inst/inst_pc are stable until the handshake.
  - On inst_ready: go to FETCH; inst_valid=0 next cycle.
  - Throughput is one instruction per 3 cycles minimum when memory responds in 1 cycle.
- DROP:
  - On imem_rsp_valid: discard the response, go to FETCH.
- FAULT:
  - fault=1, no requests, inst_valid=0. Only a redirect leaves this state.
- Redirect: has priority over every other event in every state.
  - Aligned target (redirect_pc[1:0]==0): pc_q<=redirect_pc.
    - FETCH: stay in FETCH. No request is issued in the redirect cycle.
    - WAIT: go to DROP. If imem_rsp_valid is high in the same cycle, discard that response and go to FETCH.
    - OUT: kill the instruction (inst_valid=0 next cycle), go to FETCH. A same-cycle inst_ready is void; decode is flushed by the same redirect.
    - DROP: stay in DROP. If imem_rsp_valid is high in the same cycle, go to FETCH.
    - FAULT: fault<=0, go to FETCH.
  - Misaligned target (redirect_pc[1:0]!=0): fault_pc<=redirect_pc, fault<=1, pc_q unchanged.
    - Next state is FAULT, except from WAIT (or DROP without a response), which goes to DROP and then to FAULT on the response.
    - fault asserts the cycle after the redirect.
- imem_rsp_valid in FETCH, OUT or FAULT: ignored.
- Only one request is outstanding at a time; the memory must not respond before accepting.

Test Plan:
- Sequential fetch: RESET_PC=0x100, memory with 1-cycle ready and 1-cycle response, inst_ready=1.
  - Expect requests at 0x100, 0x104, 0x108.
  - Expect inst_pc 0x100/0x104/0x108 with the matching data, one instruction every 3 cycles.
- Backpressure: inst_ready=0 for 5 cycles in OUT.
  - Expect inst/inst_pc stable, imem_req_valid=0.
  - After ready, the next request is 0x104.
- Redirect while waiting: redirect_pc=0x200 in WAIT for 0x104, response arrives 2 cycles later.
  - Expect the response dropped, never presented; next request 0x200.
  - Repeat with the response in the same cycle as the redirect: dropped, next request 0x200.
- Redirect versus presentation:
  - Redirect to 0x300 in OUT with inst_ready=1: inst_valid=0 next cycle, next request 0x300.
  - Redirect in FETCH with imem_req_ready=1: no request accepted that cycle, next request 0x300.
- Misaligned redirect: redirect_pc=0x302 in FETCH.
  - Expect fault=1, fault_pc=0x302, no requests.
  - Redirect to 0x400: fault=0, request 0x400.
- Wrap and reset:
  - pc_q=0xFFFF_FFFC fetch: next request 0x0000_0000.
  - Assert rst while in WAIT: outputs reset immediately, first request after release is RESET_PC, and the late response is ignored.
